// File: rtl/guess_leds_game.sv
// guess_leds_game: LED memory game. A random pattern of N_LIT LEDs is shown
// for a shrinking number of ticks; the player reproduces it on SW and
// presses GO. After N_ROUNDS rounds a single LED chases across LEDR.
module guess_leds_game #(
   parameter int N_LEDS      = 16,
   parameter int N_LIT       = 4,
   parameter int N_ROUNDS    = 5,
   parameter int SHOW_TICKS  = 5,
   parameter int SHOW_MIN    = 1,
   parameter int GUESS_TICKS = 500,
   parameter int BLINK_OK    = 48,
   parameter int BLINK_BAD   = 96
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              TICK,
   input  logic              GO,
   input  logic [N_LEDS-1:0] SW,
   output logic [N_LEDS-1:0] LEDR,
   output logic [5:0]        LEDG,
   output logic [3:0]        ROUNDS,
   output logic [3:0]        ROUNDS_OK
);

   localparam int IW     = $clog2(N_LEDS);
   localparam int LW     = $clog2(N_LIT + 1);
   localparam int M1     = (GUESS_TICKS > BLINK_BAD) ? GUESS_TICKS : BLINK_BAD;
   localparam int M2     = (M1 > BLINK_OK) ? M1 : BLINK_OK;
   localparam int CMAX   = (M2 > SHOW_TICKS) ? M2 : SHOW_TICKS;
   localparam int CW_RAW = $clog2(CMAX + 1);
   // At least 3 bits so the blink phase bit cnt[2] always exists.
   localparam int CW     = (CW_RAW < 3) ? 3 : CW_RAW;

   localparam logic [CW-1:0] SHOW_INIT  = CW'(SHOW_TICKS);
   localparam logic [CW-1:0] SHOW_FLOOR = CW'(SHOW_MIN);
   localparam logic [CW-1:0] GUESS_INIT = CW'(GUESS_TICKS);
   localparam logic [CW-1:0] OK_INIT    = CW'(BLINK_OK);
   localparam logic [CW-1:0] BAD_INIT   = CW'(BLINK_BAD);
   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [LW-1:0] LIT_LAST   = LW'(N_LIT - 1);
   localparam logic [3:0]    ROUND_LAST = 4'(N_ROUNDS);
   localparam logic [15:0]   LFSR_SEED  = 16'hACE1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GEN    = 3'd1,
      S_SHOW   = 3'd2,
      S_GUESS  = 3'd3,
      S_EVAL   = 3'd4,
      S_RESULT = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   function automatic logic [5:0] state_onehot(input state_t s);
      logic [5:0] oh;
      case (s)
         S_IDLE:   oh = 6'b000001;
         S_GEN:    oh = 6'b000010;
         S_SHOW:   oh = 6'b000100;
         S_GUESS:  oh = 6'b001000;
         S_EVAL:   oh = 6'b010000;
         S_RESULT: oh = 6'b100000;
         S_DONE:   oh = 6'b111111;
         default:  oh = 6'b000001;
      endcase
      return oh;
   endfunction

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      logic [3:0] r;
      if (v == 4'd15) r = v;
      else            r = v + 4'd1;
      return r;
   endfunction

   state_t            state_q, state_d;
   logic              go_q, go_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [N_LEDS-1:0] pattern_q, pattern_d;
   logic [LW-1:0]     lit_q, lit_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     show_len_q, show_len_d;
   logic [3:0]        rounds_q, rounds_d;
   logic [3:0]        rounds_ok_q, rounds_ok_d;
   logic [N_LEDS-1:0] ledr_q, ledr_d;
   logic [5:0]        ledg_q, ledg_d;
   logic              go_edge;
   logic [IW-1:0]     idx;

   assign go_edge   = GO & ~go_q;
   assign idx       = lfsr_q[IW-1:0];
   assign LEDR      = ledr_q;
   assign LEDG      = ledg_q;
   assign ROUNDS    = rounds_q;
   assign ROUNDS_OK = rounds_ok_q;

   // Next-state logic for the game sequencer, counters and LFSR.
   always_comb begin
      state_d     = state_q;
      go_d        = GO;
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      pattern_d   = pattern_q;
      lit_d       = lit_q;
      cnt_d       = cnt_q;
      show_len_d  = show_len_q;
      rounds_d    = rounds_q;
      rounds_ok_d = rounds_ok_q;
      case (state_q)
         S_IDLE: begin
            if (go_edge) begin
               pattern_d = {N_LEDS{1'b0}};
               lit_d     = {LW{1'b0}};
               state_d   = S_GEN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GEN: begin
            // Collisions with an already-lit LED simply retry next CLK.
            if (pattern_q[idx] == 1'b0) begin
               pattern_d[idx] = 1'b1;
               lit_d          = lit_q + 1'b1;
               if (lit_q == LIT_LAST) begin
                  cnt_d   = show_len_q;
                  state_d = S_SHOW;
               end else begin
                  state_d = S_GEN;
               end
            end else begin
               state_d = S_GEN;
            end
         end
         S_SHOW: begin
            if (TICK) begin
               if (cnt_q == CNT_ZERO) begin
                  cnt_d   = GUESS_INIT;
                  state_d = S_GUESS;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_GUESS: begin
            // A press and a timeout on the same CLK merge into one EVAL.
            if (go_edge || (TICK && (cnt_q == CNT_ZERO))) begin
               state_d = S_EVAL;
            end else if (TICK) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_EVAL: begin
            rounds_d = sat_inc4(rounds_q);
            if (SW == pattern_q) begin
               rounds_ok_d = sat_inc4(rounds_ok_q);
               cnt_d       = OK_INIT;
               if (show_len_q > SHOW_FLOOR) show_len_d = show_len_q - 1'b1;
               else                         show_len_d = SHOW_FLOOR;
            end else begin
               cnt_d = BAD_INIT;
            end
            state_d = S_RESULT;
         end
         S_RESULT: begin
            if (TICK) begin
               if (cnt_q == CNT_ZERO) begin
                  if (rounds_q == ROUND_LAST) state_d = S_DONE;
                  else                        state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Display values registered alongside the state they belong to.
   always_comb begin
      ledr_d = {N_LEDS{1'b0}};
      case (state_d)
         S_SHOW: begin
            ledr_d = pattern_d;
         end
         S_RESULT: begin
            if (cnt_d[2]) ledr_d = pattern_d;
            else          ledr_d = {N_LEDS{1'b0}};
         end
         S_DONE: begin
            if (state_q != S_DONE) ledr_d = {{(N_LEDS-1){1'b0}}, 1'b1};
            else if (TICK)         ledr_d = {ledr_q[N_LEDS-2:0], ledr_q[N_LEDS-1]};
            else                   ledr_d = ledr_q;
         end
         default: begin
            ledr_d = {N_LEDS{1'b0}};
         end
      endcase
      ledg_d = state_onehot(state_d);
   end

   // State and output registers; GO_q resets high so a held button is not an edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         go_q        <= 1'b1;
         lfsr_q      <= LFSR_SEED;
         pattern_q   <= {N_LEDS{1'b0}};
         lit_q       <= {LW{1'b0}};
         cnt_q       <= CNT_ZERO;
         show_len_q  <= SHOW_INIT;
         rounds_q    <= 4'd0;
         rounds_ok_q <= 4'd0;
         ledr_q      <= {N_LEDS{1'b0}};
         ledg_q      <= 6'b000001;
      end else begin
         state_q     <= state_d;
         go_q        <= go_d;
         lfsr_q      <= lfsr_d;
         pattern_q   <= pattern_d;
         lit_q       <= lit_d;
         cnt_q       <= cnt_d;
         show_len_q  <= show_len_d;
         rounds_q    <= rounds_d;
         rounds_ok_q <= rounds_ok_d;
         ledr_q      <= ledr_d;
         ledg_q      <= ledg_d;
      end
   end

endmodule

// File: tb/tb_guess_leds_game.sv
// Directed testbench for guess_leds_game (default instance plus an
// 8-LED instance for repeated pattern generation).
module tb_guess_leds_game;

   localparam logic [5:0] L_IDLE   = 6'b000001;
   localparam logic [5:0] L_GEN    = 6'b000010;
   localparam logic [5:0] L_SHOW   = 6'b000100;
   localparam logic [5:0] L_GUESS  = 6'b001000;
   localparam logic [5:0] L_EVAL   = 6'b010000;
   localparam logic [5:0] L_RESULT = 6'b100000;
   localparam logic [5:0] L_DONE   = 6'b111111;

   logic        CLK = 1'b0;
   logic        RST, TICK, GO;
   logic [15:0] SW, LEDR;
   logic [5:0]  LEDG;
   logic [3:0]  ROUNDS, ROUNDS_OK;

   logic        RST8, TICK8, GO8;
   logic [7:0]  SW8, LEDR8;
   logic [5:0]  LEDG8;
   logic [3:0]  ROUNDS8, ROUNDS_OK8;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_lfsr;
   logic [15:0] exp_pat;

   always #5 CLK = ~CLK;

   guess_leds_game dut (
      .CLK(CLK), .RST(RST), .TICK(TICK), .GO(GO), .SW(SW),
      .LEDR(LEDR), .LEDG(LEDG), .ROUNDS(ROUNDS), .ROUNDS_OK(ROUNDS_OK)
   );

   guess_leds_game #(
      .N_LEDS(8), .N_LIT(4), .N_ROUNDS(15), .SHOW_TICKS(1), .SHOW_MIN(1),
      .GUESS_TICKS(1), .BLINK_OK(1), .BLINK_BAD(1)
   ) dut8 (
      .CLK(CLK), .RST(RST8), .TICK(TICK8), .GO(GO8), .SW(SW8),
      .LEDR(LEDR8), .LEDG(LEDG8), .ROUNDS(ROUNDS8), .ROUNDS_OK(ROUNDS_OK8)
   );

   // Reference LFSR for the default instance (taps 16,14,13,11).
   always @(posedge CLK) begin
      if (RST) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic tick();
      TICK = 1'b1;
      step();
      TICK = 1'b0;
      step();
   endtask

   task automatic count_ticks(input logic [5:0] st, input int budget, output int n);
      n = 0;
      while (LEDG === st && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic do_reset();
      RST = 1'b1; GO = 1'b0; TICK = 1'b0;
      step(); step();
      RST = 1'b0;
      step();
   endtask

   // Press GO from IDLE and predict the generated pattern from the LFSR model.
   task automatic press_and_gen();
      logic [15:0] v;
      int lit, cyc;
      exp_pat = 16'h0000; lit = 0; cyc = 0;
      GO = 1'b1;
      step();
      GO = 1'b0;
      checks++;
      if (LEDG !== L_GEN) begin errors++; $display("FAIL go_to_gen: LEDG %b expected %b", LEDG, L_GEN); end
      while (lit < 4 && cyc < 64) begin
         v = m_lfsr;
         if (exp_pat[v[3:0]] == 1'b0) begin exp_pat[v[3:0]] = 1'b1; lit++; end
         step();
         cyc++;
      end
      checks++;
      if (LEDG !== L_SHOW) begin errors++; $display("FAIL gen_to_show: LEDG %b expected %b after %0d CLK", LEDG, L_SHOW, cyc); end
      checks++;
      if (LEDR !== exp_pat) begin errors++; $display("FAIL show_pattern: LEDR %h expected %h", LEDR, exp_pat); end
      checks++;
      if ($countones(LEDR) != 4) begin errors++; $display("FAIL show_popcount: got %0d expected 4", $countones(LEDR)); end
   endtask

   task automatic test_reset();
      RST = 1'b1; GO = 1'b0; TICK = 1'b0; SW = 16'h0000;
      step(); step();
      checks++; if (LEDR !== 16'h0000) begin errors++; $display("FAIL reset_ledr: got %h expected 0000", LEDR); end
      checks++; if (LEDG !== L_IDLE) begin errors++; $display("FAIL reset_ledg: got %b expected %b", LEDG, L_IDLE); end
      checks++; if (ROUNDS !== 4'd0) begin errors++; $display("FAIL reset_rounds: got %0d expected 0", ROUNDS); end
      checks++; if (ROUNDS_OK !== 4'd0) begin errors++; $display("FAIL reset_rounds_ok: got %0d expected 0", ROUNDS_OK); end
      RST = 1'b0;
      step();
      checks++; if (LEDG !== L_IDLE) begin errors++; $display("FAIL idle_after_reset: got %b expected %b", LEDG, L_IDLE); end
   endtask

   task automatic test_first_round();
      int n;
      press_and_gen();
      count_ticks(L_SHOW, 20, n);
      checks++; if (n != 6) begin errors++; $display("FAIL show_len_first: got %0d ticks expected 6", n); end
      checks++; if (LEDR !== 16'h0000) begin errors++; $display("FAIL guess_ledr: got %h expected 0000", LEDR); end
      checks++; if (LEDG !== L_GUESS) begin errors++; $display("FAIL guess_state: got %b expected %b", LEDG, L_GUESS); end
   endtask

   task automatic test_correct_guess();
      int n;
      SW = exp_pat;
      GO = 1'b1;
      step();
      GO = 1'b0;
      checks++; if (LEDG !== L_EVAL) begin errors++; $display("FAIL eval_state: got %b expected %b", LEDG, L_EVAL); end
      step();
      checks++; if (LEDG !== L_RESULT) begin errors++; $display("FAIL eval_one_clk: got %b expected %b", LEDG, L_RESULT); end
      checks++; if (ROUNDS !== 4'd1) begin errors++; $display("FAIL rounds_1: got %0d expected 1", ROUNDS); end
      checks++; if (ROUNDS_OK !== 4'd1) begin errors++; $display("FAIL rounds_ok_1: got %0d expected 1", ROUNDS_OK); end
      count_ticks(L_RESULT, 100, n);
      checks++; if (n != 49) begin errors++; $display("FAIL result_ok_len: got %0d ticks expected 49", n); end
      checks++; if (LEDG !== L_IDLE) begin errors++; $display("FAIL result_to_idle: got %b expected %b", LEDG, L_IDLE); end
      press_and_gen();
      count_ticks(L_SHOW, 20, n);
      checks++; if (n != 5) begin errors++; $display("FAIL show_len_second: got %0d ticks expected 5", n); end
   endtask

   task automatic test_timeout();
      int n, c;
      logic [15:0] e;
      SW = ~exp_pat;
      count_ticks(L_GUESS, 600, n);
      checks++; if (n != 501) begin errors++; $display("FAIL guess_timeout: got %0d ticks expected 501", n); end
      checks++; if (LEDG !== L_RESULT) begin errors++; $display("FAIL timeout_result: got %b expected %b", LEDG, L_RESULT); end
      checks++; if (ROUNDS !== 4'd2) begin errors++; $display("FAIL rounds_2: got %0d expected 2", ROUNDS); end
      checks++; if (ROUNDS_OK !== 4'd1) begin errors++; $display("FAIL rounds_ok_kept: got %0d expected 1", ROUNDS_OK); end
      c = 96; n = 0;
      while (LEDG === L_RESULT && n < 200) begin
         e = c[2] ? exp_pat : 16'h0000;
         checks++;
         if (LEDR !== e) begin errors++; $display("FAIL blink: tick %0d LEDR %h expected %h", n, LEDR, e); end
         tick();
         n++;
         c--;
      end
      checks++; if (n != 97) begin errors++; $display("FAIL result_bad_len: got %0d ticks expected 97", n); end
      checks++; if (LEDG !== L_IDLE) begin errors++; $display("FAIL bad_to_idle: got %b expected %b", LEDG, L_IDLE); end
   endtask

   task automatic test_reset_midround();
      int n;
      press_and_gen();
      GO = 1'b1; RST = 1'b1;
      step();
      checks++; if (LEDR !== 16'h0000) begin errors++; $display("FAIL mid_reset_ledr: got %h expected 0000", LEDR); end
      checks++; if (LEDG !== L_IDLE) begin errors++; $display("FAIL mid_reset_ledg: got %b expected %b", LEDG, L_IDLE); end
      checks++; if (ROUNDS !== 4'd0) begin errors++; $display("FAIL mid_reset_rounds: got %0d expected 0", ROUNDS); end
      checks++; if (ROUNDS_OK !== 4'd0) begin errors++; $display("FAIL mid_reset_rounds_ok: got %0d expected 0", ROUNDS_OK); end
      RST = 1'b0;
      repeat (5) step();
      checks++; if (LEDG !== L_IDLE) begin errors++; $display("FAIL held_go_ignored: got %b expected %b", LEDG, L_IDLE); end
      GO = 1'b0;
      step();
      press_and_gen();
      count_ticks(L_SHOW, 20, n);
      checks++; if (n != 6) begin errors++; $display("FAIL show_len_after_reset: got %0d ticks expected 6", n); end
   endtask

   task automatic test_coincide();
      int n;
      SW = exp_pat;
      repeat (500) tick();
      checks++; if (LEDG !== L_GUESS) begin errors++; $display("FAIL guess_before_timeout: got %b expected %b", LEDG, L_GUESS); end
      TICK = 1'b1; GO = 1'b1;
      step();
      TICK = 1'b0; GO = 1'b0;
      checks++; if (LEDG !== L_EVAL) begin errors++; $display("FAIL coincide_eval: got %b expected %b", LEDG, L_EVAL); end
      step();
      checks++; if (LEDG !== L_RESULT) begin errors++; $display("FAIL coincide_result: got %b expected %b", LEDG, L_RESULT); end
      checks++; if (ROUNDS !== 4'd1) begin errors++; $display("FAIL coincide_rounds: got %0d expected 1", ROUNDS); end
      checks++; if (ROUNDS_OK !== 4'd1) begin errors++; $display("FAIL coincide_rounds_ok: got %0d expected 1", ROUNDS_OK); end
      count_ticks(L_RESULT, 100, n);
      checks++; if (n != 49) begin errors++; $display("FAIL coincide_result_len: got %0d ticks expected 49", n); end
   endtask

   task automatic test_done();
      int n;
      do_reset();
      for (int r = 0; r < 5; r++) begin
         press_and_gen();
         count_ticks(L_SHOW, 20, n);
         checks++; if (n != 6 - r) begin errors++; $display("FAIL show_shrink: round %0d got %0d ticks expected %0d", r, n, 6 - r); end
         SW = exp_pat;
         GO = 1'b1; step(); GO = 1'b0; step();
         count_ticks(L_RESULT, 100, n);
         checks++; if (n != 49) begin errors++; $display("FAIL done_result_len: round %0d got %0d expected 49", r, n); end
      end
      checks++; if (LEDG !== L_DONE) begin errors++; $display("FAIL done_state: got %b expected %b", LEDG, L_DONE); end
      checks++; if (LEDR !== 16'h0001) begin errors++; $display("FAIL done_ledr0: got %h expected 0001", LEDR); end
      checks++; if (ROUNDS !== 4'd5 || ROUNDS_OK !== 4'd5) begin errors++; $display("FAIL done_counts: got %0d/%0d expected 5/5", ROUNDS, ROUNDS_OK); end
      tick();
      checks++; if (LEDR !== 16'h0002) begin errors++; $display("FAIL done_rotate1: got %h expected 0002", LEDR); end
      repeat (15) tick();
      checks++; if (LEDR !== 16'h0001) begin errors++; $display("FAIL done_wrap: got %h expected 0001", LEDR); end
      GO = 1'b1; step(); GO = 1'b0; step();
      checks++; if (LEDG !== L_DONE || LEDR !== 16'h0001) begin errors++; $display("FAIL done_go_ignored: LEDG %b LEDR %h expected %b 0001", LEDG, LEDR, L_DONE); end
   endtask

   task automatic test_random8();
      int n;
      RST8 = 1'b1; TICK8 = 1'b0; GO8 = 1'b0; SW8 = 8'h00;
      step(); step();
      RST8 = 1'b0; TICK8 = 1'b1;
      step();
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 3)) step();
         GO8 = 1'b1; step(); GO8 = 1'b0;
         n = 0;
         while (LEDG8 !== L_SHOW && n < 100) begin step(); n++; end
         checks++;
         if (LEDG8 !== L_SHOW || $countones(LEDR8) != 4) begin
            errors++; $display("FAIL rand_popcount: round %0d LEDG %b LEDR %b expected SHOW with 4 bits", i, LEDG8, LEDR8);
         end
         n = 0;
         while (LEDG8 !== L_IDLE && LEDG8 !== L_DONE && n < 50) begin step(); n++; end
         checks++;
         if (LEDG8 !== L_IDLE && LEDG8 !== L_DONE) begin
            errors++; $display("FAIL rand_round_end: round %0d LEDG %b expected IDLE or DONE", i, LEDG8);
         end
         if (LEDG8 === L_DONE) begin
            checks++;
            if (ROUNDS8 !== 4'd15 || ROUNDS_OK8 !== 4'd0) begin
               errors++; $display("FAIL rand_done_counts: got %0d/%0d expected 15/0", ROUNDS8, ROUNDS_OK8);
            end
         end
         if (LEDG8 !== L_IDLE) begin
            RST8 = 1'b1; step(); RST8 = 1'b0; step();
         end
      end
      TICK8 = 1'b0;
   endtask

   initial begin
      RST = 1'b1; TICK = 1'b0; GO = 1'b0; SW = 16'h0000;
      RST8 = 1'b1; TICK8 = 1'b0; GO8 = 1'b0; SW8 = 8'h00;
      test_reset();
      test_first_round();
      test_correct_guess();
      test_timeout();
      test_reset_midround();
      test_coincide();
      test_done();
      test_random8();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
